// File: rtl/gcd_operand_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : gcd_operand_driver_if
// Description : Operand, GCD-engine and response signals of the GCD operand
//               driver. master = the driver block, slave = its surroundings
//               (operand source, GCD engine, response consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface gcd_operand_driver_if;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        gcd_start;
   logic [15:0] gcd_data;
   logic        gcd_done;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_status;
   logic [16:0] rsp_cycles;

   modport master (
      input  op_valid, op_a, op_b, gcd_done, rsp_ready,
      output op_ready, gcd_start, gcd_data, rsp_valid, rsp_status, rsp_cycles
   );

   modport slave (
      output op_valid, op_a, op_b, gcd_done, rsp_ready,
      input  op_ready, gcd_start, gcd_data, rsp_valid, rsp_status, rsp_cycles
   );
endinterface
`default_nettype wire

// File: rtl/gcd_operand_driver.sv
`default_nettype none
// ============================================================================
// Module      : gcd_operand_driver
// Description : Accepts an operand pair, loads it serially into a GCD engine
//               (start pulse with A, then B), waits for completion with a
//               stale-done mask and a timeout, and returns a status response.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_operand_driver #(
   parameter int unsigned TIMEOUT   = 70000,
   parameter int unsigned DONE_MASK = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gcd_operand_driver_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   localparam logic [16:0] c_timeout   = 17'(TIMEOUT);
   localparam logic [16:0] c_done_mask = 17'(DONE_MASK);
   localparam logic [16:0] c_cnt_max   = '1;
   localparam logic [1:0]  c_st_ok     = 2'b00;
   localparam logic [1:0]  c_st_zero   = 2'b01;
   localparam logic [1:0]  c_st_tmo    = 2'b10;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_op_b;
   logic [15:0] r_data;
   logic [16:0] r_cnt;
   logic [1:0]  r_status;
   logic [16:0] r_cycles;

   logic        w_accept;
   logic        w_zero;
   logic        w_done_hit;
   logic        w_timeout_hit;

   assign w_accept      = bus.op_valid && (r_state == ST_IDLE);
   assign w_zero        = (bus.op_a == 16'd0) || (bus.op_b == 16'd0);
   // Done seen inside the mask window is leftover from the previous operation.
   assign w_done_hit    = (r_cnt > c_done_mask) && bus.gcd_done;
   assign w_timeout_hit = (r_cnt >= c_timeout);

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; done acceptance is checked ahead of the timeout.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = w_zero ? ST_RESP : ST_LOAD_A;
            end
         end
         ST_LOAD_A: w_next_state = ST_LOAD_B;
         ST_LOAD_B: w_next_state = ST_WAIT;
         ST_WAIT: begin
            if (w_done_hit || w_timeout_hit) begin
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operand capture, serial bus value, WAIT counter and response fields.
   // gcd_data is only rewritten when a load starts, so a zero-operand request
   // leaves the engine interface exactly as it was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_b   <= 16'd0;
         r_data   <= 16'd0;
         r_cnt    <= 17'd0;
         r_status <= c_st_ok;
         r_cycles <= 17'd0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op_b <= bus.op_b;
                  if (w_zero) begin
                     r_status <= c_st_zero;
                     r_cycles <= 17'd0;
                  end else begin
                     r_data <= bus.op_a;
                  end
               end
            end
            ST_LOAD_A: begin
               r_data <= r_op_b;
            end
            ST_LOAD_B: begin
               r_cnt <= 17'd1;
            end
            ST_WAIT: begin
               if (w_done_hit) begin
                  r_status <= c_st_ok;
                  r_cycles <= r_cnt;
               end else if (w_timeout_hit) begin
                  r_status <= c_st_tmo;
                  r_cycles <= c_timeout;
               end else if (r_cnt != c_cnt_max) begin
                  r_cnt <= r_cnt + 17'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.op_ready   = (r_state == ST_IDLE);
   assign bus.gcd_start  = (r_state == ST_LOAD_A);
   assign bus.gcd_data   = r_data;
   assign bus.rsp_valid  = (r_state == ST_RESP);
   assign bus.rsp_status = r_status;
   assign bus.rsp_cycles = r_cycles;

endmodule
`default_nettype wire

// File: doc/gcd_operand_driver.md
GCD_OPERAND_DRIVER -- requirements
Module: gcd_operand_driver

Interface
REQ-001 Parameter TIMEOUT, default 70000, SHALL be the max WAIT cycles before abort (range 4..131071).
REQ-002 Parameter DONE_MASK, default 2, SHALL be the WAIT cycles during which gcd_done is ignored (range 0..TIMEOUT-1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 op_valid  input  1  SHALL indicate an operand pair is offered.
REQ-006 op_ready  output  1  SHALL indicate the block accepts a pair this cycle.
REQ-007 op_a  input  16  SHALL be operand A, sampled at acceptance.
REQ-008 op_b  input  16  SHALL be operand B, sampled at acceptance.
REQ-009 gcd_start  output  1  SHALL be the start pulse to the GCD engine.
REQ-010 gcd_data  output  16  SHALL be the serial operand bus to the GCD engine.
REQ-011 gcd_done  input  1  SHALL be the level completion flag from the GCD engine.
REQ-012 rsp_valid  output  1  SHALL indicate a response is presented.
REQ-013 rsp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-014 rsp_status  output  2  SHALL encode 00 OK, 01 ZERO_OPERAND, 10 TIMEOUT; 11 is never driven.
REQ-015 rsp_cycles  output  17  SHALL report WAIT cycles elapsed, counting from 1.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_A, LOAD_B, WAIT, RESP; no other states reachable.
REQ-017 op_ready SHALL be 1 only in IDLE; acceptance = op_valid & op_ready on a rising edge.
REQ-018 On acceptance, op_a/op_b SHALL be registered; if either is 0, next state RESP with status 01 and rsp_cycles 0, the GCD interface untouched.
REQ-019 Otherwise next state LOAD_A.
REQ-020 LOAD_A (exactly 1 cycle): gcd_start=1, gcd_data=A; then LOAD_B.
REQ-021 LOAD_B (exactly 1 cycle): gcd_start=0, gcd_data=B; then WAIT.
REQ-022 In WAIT and RESP, gcd_data SHALL hold B and gcd_start SHALL be 0.
REQ-023 In IDLE, gcd_data SHALL hold its last driven value (0 after reset).
REQ-024 WAIT cycle counter SHALL load 1 on WAIT entry and increment each WAIT cycle; it saturates and never wraps.
REQ-025 In WAIT, if counter > DONE_MASK and gcd_done=1, next state RESP with status 00 and rsp_cycles = counter.
REQ-026 In WAIT, gcd_done=1 while counter <= DONE_MASK SHALL be ignored, as stale done from a prior operation.
REQ-027 In WAIT, if counter = TIMEOUT and done was not accepted, next state RESP with status 10 and rsp_cycles = TIMEOUT.
REQ-028 Done acceptance SHALL take priority over timeout in the same cycle.
REQ-029 In RESP, rsp_valid=1 and rsp_status/rsp_cycles SHALL be stable until rsp_ready=1.
REQ-030 The RESP->IDLE transition SHALL occur on the edge where rsp_ready=1; rsp_valid drops next cycle.
REQ-031 op_valid SHALL be ignored in all states except IDLE; no queuing.
REQ-032 Latency SHALL be: accept -> gcd_start high next cycle; done sampled -> rsp_valid high next cycle.
REQ-033 Zero-operand latency: accept -> rsp_valid high next cycle.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, op_ready=1, gcd_start=0, gcd_data=0, rsp_valid=0, rsp_status=00, rsp_cycles=0, and clear the counter and operand registers.
REQ-035 Reset asserted mid-operation (any state) SHALL abort it with no response issued; the first post-reset acceptance starts a clean operation.
REQ-036 Deassertion SHALL take effect at the first rising clk edge after rst_n rises.

Verification
REQ-037 A=48, B=18, gcd_done rises 10 cycles into WAIT -> gcd_start high 1 cycle with gcd_data=48; next cycle gcd_data=18; rsp_status=00, rsp_cycles=10.
REQ-038 A=0, B=7 -> no gcd_start pulse; rsp_valid the cycle after accept; rsp_status=01, rsp_cycles=0.
REQ-039 gcd_done held 1 throughout, DONE_MASK=2 -> done accepted at counter=3; rsp_cycles=3.
REQ-040 TIMEOUT=8, gcd_done never rises -> rsp_status=10, rsp_cycles=8 after 8 WAIT cycles.
REQ-041 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and fields stable all 5 cycles; op_ready=0 throughout.
REQ-042 rst_n pulsed low during WAIT -> outputs at reset values asynchronously; no rsp_valid; next pair A=9, B=6 processed normally.
